// File: rtl/cpu_gen_pkg.sv
// Package lib_cpu: opcode and FSM state enums plus instruction-field extraction
// shared by the cpu_gen core and its ALU.
package lib_cpu;

  typedef enum logic [3:0] {
    OpAddImm = 4'h0,
    OpMovRs  = 4'h1,
    OpIn     = 4'h2,
    OpMovImm = 4'h3,
    OpAddRs  = 4'h4,
    OpSub    = 4'h5,
    OpAnd    = 4'h6,
    OpOr     = 4'h7,
    OpXor    = 4'h8,
    OpOutRs  = 4'h9,
    OpHalt   = 4'hA,
    OpOutImm = 4'hB,
    OpCall   = 4'hC,
    OpRet    = 4'hD,
    OpJnc    = 4'hE,
    OpJmp    = 4'hF
  } GEN_OPCODE;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StExec,
    StHalt
  } GEN_STATE;

  typedef enum logic [1:0] {
    FieldOp,
    FieldRd,
    FieldRs
  } GEN_FIELD;

  // Widest supported data path; callers zero-extend their instruction word to this.
  localparam int unsigned MaxDataW  = 64;
  localparam int unsigned MaxInstrW = 12 + MaxDataW;

  // Extract a 4-bit field from {op, rd, rs, imm[data_w-1:0]}.
  function automatic logic [3:0] instr_field(input logic [MaxInstrW-1:0] instr,
                                             input int unsigned data_w,
                                             input GEN_FIELD field);
    int unsigned shamt;
    case (field)
      FieldOp: shamt = data_w + 8;
      FieldRd: shamt = data_w + 4;
      default: shamt = data_w;
    endcase
    return 4'(instr >> shamt);
  endfunction

endpackage

// File: rtl/cpu_gen_alu.sv
// cpu_gen_alu: combinational datapath for the register-writing opcodes.
// Produces the result, carry/borrow and whether rd is written.
module cpu_gen_alu
  import lib_cpu::*;
#(
  parameter int unsigned DATA_W = 4
) (
  input  GEN_OPCODE         op,
  input  logic [DATA_W-1:0] rd_val,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              we
);

  // Decode op into result/carry; carry is only ever set by ADD/SUB.
  always_comb begin
    result = '0;
    carry  = 1'b0;
    we     = 1'b0;
    case (op)
      OpAddImm: begin
        {carry, result} = {1'b0, rd_val} + {1'b0, imm};
        we = 1'b1;
      end
      OpAddRs: begin
        {carry, result} = {1'b0, rd_val} + {1'b0, rs_val};
        we = 1'b1;
      end
      OpSub: begin
        // Top bit of the widened difference is the borrow.
        {carry, result} = {1'b0, rd_val} - {1'b0, rs_val};
        we = 1'b1;
      end
      OpMovRs, OpIn: begin
        result = rs_val;
        we     = 1'b1;
      end
      OpMovImm: begin
        result = imm;
        we     = 1'b1;
      end
      OpAnd: begin
        result = rd_val & rs_val;
        we     = 1'b1;
      end
      OpOr: begin
        result = rd_val | rs_val;
        we     = 1'b1;
      end
      OpXor: begin
        result = rd_val ^ rs_val;
        we     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_gen.sv
// cpu_gen: parametrised multi-cycle register-file CPU (IDLE/FETCH/EXEC/HALT).
// Optional return stack enabled by defining CPU_GEN_STACK_EN; otherwise CALL/RET
// are NOPs and fault is tied low.
module cpu_gen
  import lib_cpu::*;
#(
  parameter int unsigned DATA_W      = 4,
  parameter int unsigned NUM_REGS    = 2,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned STACK_DEPTH = 4,
  localparam int unsigned INSTR_W    = 12 + DATA_W
) (
  input  logic               clk,
  input  logic               n_reset,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ready,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic [DATA_W-1:0]  io_in,
  output logic [DATA_W-1:0]  io_out,
  output logic               io_out_strobe,
  output logic               halted,
  output logic               fault,
  input  logic [3:0]         dbg_sel,
  output logic [DATA_W-1:0]  dbg_data
);

  GEN_STATE          state_q, state_d;
  logic [ADDR_W-1:0] ip_q, ip_d, ip_inc;
  logic              c_q;
  logic [INSTR_W-1:0] ir_q;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] io_out_q;
  logic              strobe_q;

  GEN_OPCODE         op;
  logic [3:0]        rd_idx, rs_idx;
  logic [DATA_W-1:0] imm, rd_val, rs_val, alu_b, alu_result, out_val;
  logic [ADDR_W-1:0] jump_target;
  logic              alu_carry, alu_we, out_we, halt_req, stack_fault;

  assign op          = GEN_OPCODE'(instr_field(MaxInstrW'(ir_q), DATA_W, FieldOp));
  assign rd_idx      = instr_field(MaxInstrW'(ir_q), DATA_W, FieldRd);
  assign rs_idx      = instr_field(MaxInstrW'(ir_q), DATA_W, FieldRs);
  assign imm         = ir_q[DATA_W-1:0];
  assign jump_target = imm[ADDR_W-1:0];
  assign ip_inc      = ip_q + ADDR_W'(1);

  // Register-file reads; out-of-range indices read as zero.
  always_comb begin
    rd_val   = '0;
    rs_val   = '0;
    dbg_data = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == 4'(i))  rd_val   = regs_q[i];
      if (rs_idx == 4'(i))  rs_val   = regs_q[i];
      if (dbg_sel == 4'(i)) dbg_data = regs_q[i];
    end
  end

  // IN reuses the MOV rd,rs path with io_in as the source operand.
  assign alu_b = (op == OpIn) ? io_in : rs_val;

  cpu_gen_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op     (op),
    .rd_val (rd_val),
    .rs_val (alu_b),
    .imm    (imm),
    .result (alu_result),
    .carry  (alu_carry),
    .we     (alu_we)
  );

`ifdef CPU_GEN_STACK_EN
  localparam int unsigned SpW = $clog2(STACK_DEPTH + 1);

  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic [SpW-1:0]    sp_q;
  logic [ADDR_W-1:0] stack_top;
  logic              stack_full, stack_empty, push, pop, fault_q;

  assign stack_full  = (sp_q == SpW'(STACK_DEPTH));
  assign stack_empty = (sp_q == '0);

  // Entry just below the stack pointer is the return address.
  always_comb begin
    stack_top = '0;
    for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
      if (sp_q == SpW'(i + 1)) stack_top = stack_q[i];
    end
  end
`else
  assign stack_fault = 1'b0;
`endif

  // EXEC control: next ip, output write, halt and stack requests.
  always_comb begin
    ip_d     = ip_inc;
    halt_req = 1'b0;
    out_we   = 1'b0;
    out_val  = rs_val;
`ifdef CPU_GEN_STACK_EN
    stack_fault = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
`endif
    case (op)
      OpJnc:    if (!c_q) ip_d = jump_target;
      OpJmp:    ip_d = jump_target;
      OpHalt:   halt_req = 1'b1;
      OpOutRs:  out_we = 1'b1;
      OpOutImm: begin
        out_we  = 1'b1;
        out_val = imm;
      end
`ifdef CPU_GEN_STACK_EN
      OpCall: begin
        if (stack_full) begin
          stack_fault = 1'b1;
        end else begin
          push = 1'b1;
          ip_d = jump_target;
        end
      end
      OpRet: begin
        if (stack_empty) begin
          stack_fault = 1'b1;
        end else begin
          pop  = 1'b1;
          ip_d = stack_top;
        end
      end
`endif
      default: ;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!n_reset) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = StFetch;
      StFetch: if (mem_ready) state_d = StExec;
      StExec:  state_d = (halt_req || stack_fault) ? StHalt : StFetch;
      StHalt:  state_d = StHalt;
    endcase
  end

  // FSM outputs, decoded from the current state only.
  always_comb begin
    mem_req = (state_q == StFetch);
    halted  = (state_q == StHalt);
  end

  // Datapath: instruction latch in FETCH, architectural commit in EXEC.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      ip_q     <= '0;
      c_q      <= 1'b0;
      ir_q     <= '0;
      io_out_q <= '0;
      strobe_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      strobe_q <= 1'b0;
      if (state_q == StFetch && mem_ready) ir_q <= mem_rdata;
      // A stack fault aborts the whole instruction, flags included.
      if (state_q == StExec && !stack_fault) begin
        ip_q <= ip_d;
        c_q  <= alu_carry;
        if (out_we) begin
          io_out_q <= out_val;
          strobe_q <= 1'b1;
        end
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
          if (alu_we && rd_idx == 4'(i)) regs_q[i] <= alu_result;
        end
      end
    end
  end

`ifdef CPU_GEN_STACK_EN
  // Return stack push/pop and sticky fault flag.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      sp_q    <= '0;
      fault_q <= 1'b0;
      for (int unsigned i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else if (state_q == StExec) begin
      if (stack_fault) fault_q <= 1'b1;
      if (push) begin
        for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
          if (sp_q == SpW'(i)) stack_q[i] <= ip_inc;
        end
        sp_q <= sp_q + SpW'(1);
      end else if (pop) begin
        sp_q <= sp_q - SpW'(1);
      end
    end
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  assign mem_addr      = ip_q;
  assign io_out        = io_out_q;
  assign io_out_strobe = strobe_q;

endmodule

// File: tb/tb_cpu_gen.sv
// Self-checking bench for cpu_gen: directed scenarios plus random programs checked
// against an instruction-level reference model.
module tb_cpu_gen;
  localparam int DW = 8;
  localparam int NR = 4;
  localparam int AW = 4;
  localparam int SD = 2;
  localparam int IW = 12 + DW;

  logic          clk = 1'b0;
  logic          n_reset;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ready;
  logic [IW-1:0] mem_rdata;
  logic [DW-1:0] io_in;
  logic [DW-1:0] io_out;
  logic          io_out_strobe;
  logic          halted;
  logic          fault;
  logic [3:0]    dbg_sel;
  logic [DW-1:0] dbg_data;

  logic [IW-1:0] prog [16];
  assign mem_rdata = prog[mem_addr];

  always #10 clk = ~clk;

  cpu_gen #(
    .DATA_W      (DW),
    .NUM_REGS    (NR),
    .ADDR_W      (AW),
    .STACK_DEPTH (SD)
  ) dut (
    .clk           (clk),
    .n_reset       (n_reset),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata),
    .io_in         (io_in),
    .io_out        (io_out),
    .io_out_strobe (io_out_strobe),
    .halted        (halted),
    .fault         (fault),
    .dbg_sel       (dbg_sel),
    .dbg_data      (dbg_data)
  );

  int checks = 0;
  int errors = 0;

  // Reference model architectural state.
  int m_ip, m_c, m_out, m_strobe, m_halted, m_fault;
  int m_r [16];
  int m_stack [$];

  function automatic logic [IW-1:0] ins(input int op, input int rd, input int rs, input int imm);
    logic [IW-1:0] w;
    w = {4'(op), 4'(rd), 4'(rs), DW'(imm)};
    return w;
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) prog[i] = '0;
  endtask

  task automatic model_reset();
    m_ip = 0; m_c = 0; m_out = 0; m_strobe = 0; m_halted = 0; m_fault = 0;
    for (int i = 0; i < 16; i++) m_r[i] = 0;
    m_stack.delete();
  endtask

  // Executes one instruction per the ISA rules using plain integer arithmetic.
  task automatic model_exec(input logic [IW-1:0] w, input int io);
    int op, rd, rs, imm, a, b, res, nc, nip, wr;
    op  = int'(w[IW-1:IW-4]);
    rd  = int'(w[IW-5:IW-8]);
    rs  = int'(w[IW-9:IW-12]);
    imm = int'(w[DW-1:0]);
    a   = (rd < NR) ? m_r[rd] : 0;
    b   = (rs < NR) ? m_r[rs] : 0;
    nip = (m_ip + 1) % (1 << AW);
    res = 0; nc = 0; wr = 0;
    m_strobe = 0;
    case (op)
      'h0: begin res = a + imm; nc = (res >= 256); wr = 1; end
      'h4: begin res = a + b;   nc = (res >= 256); wr = 1; end
      'h5: begin res = a - b;   nc = (a < b); if (res < 0) res += 256; wr = 1; end
      'h1: begin res = b;   wr = 1; end
      'h3: begin res = imm; wr = 1; end
      'h2: begin res = io;  wr = 1; end
      'h6: begin res = a & b; wr = 1; end
      'h7: begin res = a | b; wr = 1; end
      'h8: begin res = a ^ b; wr = 1; end
      'h9: begin m_out = b;   m_strobe = 1; end
      'hB: begin m_out = imm; m_strobe = 1; end
      'hA: m_halted = 1;
`ifdef CPU_GEN_STACK_EN
      'hC: begin
        if (m_stack.size() == SD) begin m_fault = 1; m_halted = 1; return; end
        m_stack.push_back(nip);
        nip = imm % (1 << AW);
      end
      'hD: begin
        if (m_stack.size() == 0) begin m_fault = 1; m_halted = 1; return; end
        nip = m_stack.pop_back();
      end
`endif
      'hE: if (m_c == 0) nip = imm % (1 << AW);
      'hF: nip = imm % (1 << AW);
      default: ;
    endcase
    m_c = nc;
    if (wr != 0 && rd < NR) m_r[rd] = res % 256;
    m_ip = nip;
  endtask

  task automatic do_reset();
    n_reset = 1'b0; mem_ready = 1'b0; io_in = '0; dbg_sel = '0;
    @(posedge clk); #1;
    n_reset = 1'b1;
    @(posedge clk); #1;
    model_reset();
  endtask

  // Drives one instruction through FETCH (with stalls) and EXEC, then compares the
  // DUT's visible state against the model.
  task automatic run_instr(input int stalls, input int io, input string tag);
    logic [IW-1:0] w;
    for (int s = 0; s <= stalls; s++) begin
      mem_ready = (s == stalls);
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== AW'(m_ip)) begin
        errors++;
        $display("FAIL %s fetch: req=%b addr=%0d, required req=1 addr=%0d",
                 tag, mem_req, mem_addr, m_ip);
      end
      @(posedge clk); #1;
    end
    mem_ready = 1'($urandom_range(0, 1));
    io_in = DW'(io);
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL %s exec_req: req=%b, required 0", tag, mem_req);
    end
    w = prog[m_ip];
    @(posedge clk); #1;
    mem_ready = 1'b0;
    model_exec(w, io);
    checks++;
    if (mem_addr !== AW'(m_ip) || halted !== 1'(m_halted) || fault !== 1'(m_fault)) begin
      errors++;
      $display("FAIL %s ctl: addr=%0d halted=%b fault=%b, required addr=%0d halted=%0d fault=%0d",
               tag, mem_addr, halted, fault, m_ip, m_halted, m_fault);
    end
    checks++;
    if (io_out !== DW'(m_out) || io_out_strobe !== 1'(m_strobe)) begin
      errors++;
      $display("FAIL %s io: out=%0h strobe=%b, required out=%0h strobe=%0d",
               tag, io_out, io_out_strobe, m_out, m_strobe);
    end
    for (int i = 0; i < NR; i++) begin
      dbg_sel = 4'(i); #1;
      checks++;
      if (dbg_data !== DW'(m_r[i])) begin
        errors++;
        $display("FAIL %s r%0d: got %0h, required %0h", tag, i, dbg_data, m_r[i]);
      end
    end
    dbg_sel = 4'($urandom_range(NR, 15)); #1;
    checks++;
    if (dbg_data !== '0) begin
      errors++;
      $display("FAIL %s dbg_oob sel=%0d: got %0h, required 0", tag, dbg_sel, dbg_data);
    end
  endtask

  task automatic test_reset();
    n_reset = 1'b0; mem_ready = 1'b1; io_in = 8'hA5; dbg_sel = '0;
    clear_prog();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== '0 || io_out !== '0 || io_out_strobe !== 1'b0 ||
        halted !== 1'b0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b addr=%0d out=%0h strobe=%b halted=%b fault=%b, required all 0",
               mem_req, mem_addr, io_out, io_out_strobe, halted, fault);
    end
    for (int i = 0; i < NR; i++) begin
      dbg_sel = 4'(i); #1;
      checks++;
      if (dbg_data !== '0) begin
        errors++;
        $display("FAIL reset_r%0d: got %0h, required 0", i, dbg_data);
      end
    end
    n_reset = 1'b1; mem_ready = 1'b0;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_req: got %b, required 0", mem_req);
    end
    @(posedge clk); #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== '0) begin
      errors++;
      $display("FAIL reset_first_fetch: req=%b addr=%0d, required req=1 addr=0", mem_req, mem_addr);
    end
    model_reset();
  endtask

  task automatic test_add_jnc();
    clear_prog();
    prog[0] = ins('h3, 0, 0, 'hF0);
    prog[1] = ins('h0, 0, 0, 'h20);
    prog[2] = ins('hE, 0, 0, 'h00);
    do_reset();
    for (int i = 0; i < 3; i++) run_instr(0, 0, "add_jnc");
    dbg_sel = 4'd0; #1;
    checks++;
    if (dbg_data !== 8'h10 || mem_addr !== 4'd3) begin
      errors++;
      $display("FAIL add_jnc_final: r0=%0h ip=%0d, required r0=10 ip=3", dbg_data, mem_addr);
    end
  endtask

  task automatic test_stall();
    clear_prog();
    prog[0] = ins('h3, 2, 0, 'h33);
    do_reset();
    for (int c = 1; c <= 3; c++) begin
      mem_ready = 1'b0;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 4'd0) begin
        errors++;
        $display("FAIL stall_cycle%0d: req=%b addr=%0d, required req=1 addr=0", c, mem_req, mem_addr);
      end
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== 4'd0) begin
      errors++;
      $display("FAIL stall_exec_cycle5: req=%b addr=%0d, required req=0 addr=0", mem_req, mem_addr);
    end
    @(posedge clk); #1;
    dbg_sel = 4'd2; #1;
    checks++;
    if (dbg_data !== 8'h33 || mem_addr !== 4'd1) begin
      errors++;
      $display("FAIL stall_commit: r2=%0h ip=%0d, required r2=33 ip=1", dbg_data, mem_addr);
    end
  endtask

  task automatic test_io();
    clear_prog();
    prog[0] = ins('h2, 1, 0, 0);
    prog[1] = ins('h9, 0, 1, 0);
    do_reset();
    run_instr(0, 'h5A, "io_in");
    run_instr(0, 'h00, "io_out");
    checks++;
    if (io_out !== 8'h5A || io_out_strobe !== 1'b1) begin
      errors++;
      $display("FAIL io_pulse: out=%0h strobe=%b, required out=5a strobe=1", io_out, io_out_strobe);
    end
    @(posedge clk); #1;
    checks++;
    if (io_out_strobe !== 1'b0 || io_out !== 8'h5A) begin
      errors++;
      $display("FAIL io_pulse_end: out=%0h strobe=%b, required out=5a strobe=0", io_out, io_out_strobe);
    end
  endtask

  task automatic test_wrap();
    clear_prog();
    prog[0]  = ins('hF, 0, 0, 15);
    prog[15] = ins('h0, 0, 0, 1);
    do_reset();
    run_instr(0, 0, "wrap_jmp");
    run_instr(1, 0, "wrap_add");
    checks++;
    if (mem_addr !== 4'd0) begin
      errors++;
      $display("FAIL wrap_addr: got %0d, required 0", mem_addr);
    end
  endtask

  task automatic test_halt();
    clear_prog();
    prog[0] = ins('h3, 1, 0, 'h77);
    prog[1] = ins('hB, 0, 0, 'h3C);
    prog[2] = ins('hA, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 3; i++) run_instr(0, 0, "halt_prog");
    for (int c = 0; c < 8; c++) begin
      mem_ready = 1'b1;
      checks++;
      if (halted !== 1'b1 || mem_req !== 1'b0) begin
        errors++;
        $display("FAIL halt_hold%0d: halted=%b req=%b, required halted=1 req=0", c, halted, mem_req);
      end
      @(posedge clk); #1;
    end
    n_reset = 1'b0;
    @(posedge clk); #1;
    n_reset = 1'b1; mem_ready = 1'b0;
    dbg_sel = 4'd1; #1;
    checks++;
    if (halted !== 1'b0 || mem_req !== 1'b0 || mem_addr !== '0 || io_out !== '0 ||
        io_out_strobe !== 1'b0 || fault !== 1'b0 || dbg_data !== '0) begin
      errors++;
      $display("FAIL halt_reset: halted=%b req=%b addr=%0d out=%0h strobe=%b fault=%b r1=%0h, required all 0",
               halted, mem_req, mem_addr, io_out, io_out_strobe, fault, dbg_data);
    end
    @(posedge clk); #1;
    model_reset();
  endtask

  task automatic test_call_ret();
    clear_prog();
    prog[0]  = ins('h3, 0, 0, 'hFF);
    prog[1]  = ins('h0, 0, 0, 'h01);
    prog[2]  = ins('hC, 0, 0, 9);
    prog[3]  = ins('hE, 0, 0, 12);
    prog[9]  = ins('hE, 0, 0, 12);
    prog[12] = ins('hD, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 5; i++) run_instr(0, 0, "call_ret");
`ifdef CPU_GEN_STACK_EN
    checks++;
    if (mem_addr !== 4'd3 || fault !== 1'b0) begin
      errors++;
      $display("FAIL call_ret_return: ip=%0d fault=%b, required ip=3 fault=0", mem_addr, fault);
    end
    clear_prog();
    prog[0] = ins('hC, 0, 0, 1);
    prog[1] = ins('hC, 0, 0, 2);
    prog[2] = ins('hC, 0, 0, 3);
    do_reset();
    for (int i = 0; i < 3; i++) run_instr(0, 0, "stack_over");
    checks++;
    if (fault !== 1'b1 || halted !== 1'b1 || mem_addr !== 4'd2) begin
      errors++;
      $display("FAIL stack_overflow: fault=%b halted=%b ip=%0d, required fault=1 halted=1 ip=2",
               fault, halted, mem_addr);
    end
    clear_prog();
    prog[0] = ins('hD, 0, 0, 0);
    do_reset();
    run_instr(0, 0, "stack_under");
    checks++;
    if (fault !== 1'b1 || halted !== 1'b1 || mem_addr !== 4'd0) begin
      errors++;
      $display("FAIL stack_underflow: fault=%b halted=%b ip=%0d, required fault=1 halted=1 ip=0",
               fault, halted, mem_addr);
    end
`else
    checks++;
    if (mem_addr !== 4'd13 || fault !== 1'b0) begin
      errors++;
      $display("FAIL call_ret_nop: ip=%0d fault=%b, required ip=13 fault=0", mem_addr, fault);
    end
`endif
  endtask

  task automatic test_random();
    int op;
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 16; i++) begin
        do op = $urandom_range(0, 15); while (op == 'hA || op == 'hC || op == 'hD);
        prog[i] = ins(op, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 255));
      end
      do_reset();
      for (int n = 0; n < 40; n++) run_instr($urandom_range(0, 2), $urandom_range(0, 255), "random");
    end
  endtask

  initial begin
    test_reset();
    test_add_jnc();
    test_stall();
    test_io();
    test_wrap();
    test_halt();
    test_call_ret();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_gen.md
# cpu_gen

Parametrised multi-cycle successor to the 4-bit TD4-style core: a register-file CPU with configurable data width, register count and program-address width. Fetch goes through a ready-qualified memory request port instead of a zero-latency ROM. It adds SUB/logic ops, HALT, an output strobe and a debug read port. It sits between program memory and the board I/O, where the fixed-width core sat before.

## Interface
- DATA_W, 4: register, ALU, I/O and immediate width; must be ≥ ADDR_W.
- NUM_REGS, 2: general registers, 2..16.
- ADDR_W, 4: program-address width; the instruction pointer wraps modulo 2^ADDR_W.
- STACK_DEPTH, 4: return-stack entries; used only with CPU_GEN_STACK_EN.
- INSTR_W: derived, 12+DATA_W. Layout is {op[3:0], rd[3:0], rs[3:0], imm[DATA_W-1:0]}.
- Ports:
  - clk  in  1  clock; all state changes on its rising edge.
  - n_reset  in  1  synchronous, active-low reset.
  - mem_req  out  1  fetch request.
  - mem_addr  out  ADDR_W  fetch address, equal to ip.
  - mem_ready  in  1  qualifies mem_rdata in the same cycle as mem_req.
  - mem_rdata  in  INSTR_W  instruction word.
  - io_in  in  DATA_W  input port, sampled in EXEC.
  - io_out  out  DATA_W  registered output port.
  - io_out_strobe  out  1  one-cycle pulse, high in the cycle after io_out is written.
  - halted  out  1  core is in HALT.
  - fault  out  1  stack over/underflow caused the halt.
  - dbg_sel  in  4  register index for the debug port.
  - dbg_data  out  DATA_W  combinational read of regs[dbg_sel]; reads 0 when dbg_sel ≥ NUM_REGS.

## Operation
- States:
  - IDLE: entered on reset. Moves to FETCH in the first cycle n_reset is high.
  - FETCH: mem_req=1, mem_addr=ip. If mem_ready=1 in that cycle, latch mem_rdata into ir and go to EXEC. Otherwise stay in FETCH with address held stable.
  - EXEC: one cycle. Commits register, flag, ip and output updates at the edge, then returns to FETCH. Goes to HALT instead for HALT or a stack fault.
  - HALT: mem_req=0. Leaves only on reset.
- Opcodes (ip ← ip+1 unless stated):
  - 0x0 ADD rd,imm; 0x4 ADD rd,rs: C ← carry-out.
  - 0x5 SUB rd,rs: C ← borrow.
  - 0x1 MOV rd,rs; 0x3 MOV rd,imm; 0x2 IN rd (rd ← io_in).
  - 0x6 AND, 0x7 OR, 0x8 XOR, each rd ← rd op rs.
  - 0x9 OUT rs; 0xB OUT imm.
  - 0xA HALT.
  - 0xC CALL imm; 0xD RET.
  - 0xE JNC imm: jump if C=0.
  - 0xF JMP imm.
- Carry flag: every opcode other than ADD/SUB clears C, including JNC whether or not it jumps.
- Jump targets are imm[ADDR_W-1:0].
- Arithmetic is modulo 2^DATA_W.
- A write to rd ≥ NUM_REGS is dropped. A read of rs ≥ NUM_REGS returns 0.

## Timing
- Reset values: all regs, ip, C, io_out, stack pointer = 0; io_out_strobe=0, halted=0, fault=0; state=IDLE, so mem_req=0.
- Instruction latency is 2 cycles with zero-wait memory, plus one cycle per cycle mem_ready is low.
- mem_req is driven combinationally from state. mem_ready is ignored outside FETCH.
- halted rises in the cycle after the HALT EXEC and stays high until reset.
- Reset mid-FETCH or mid-EXEC aborts the instruction; no partial commit.
- ip 2^ADDR_W−1 +1 wraps to 0, and a CALL there pushes 0.

## Configuration
- CPU_GEN_STACK_EN defined:
  - Instantiates a STACK_DEPTH × ADDR_W return stack.
  - CALL pushes ip+1 and jumps to imm. RET pops into ip.
  - CALL when the stack is full, or RET when it is empty, sets fault=1 and enters HALT with no register or ip change.
- Undefined: 0xC/0xD behave as NOP (C←0, ip+1), no stack logic exists, and fault is tied 0.

## Structure
- Package lib_cpu holds:
  - GEN_OPCODE enum (4-bit).
  - GEN_STATE enum (IDLE/FETCH/EXEC/HALT).
  - Parametrisable instruction-field extraction function.
- Sub-module cpu_gen_alu: combinational; takes op, rd value, rs value, imm; returns result, carry and write-enable.

## Test plan
- DATA_W=8, zero-wait memory. Program: MOV r0,0xF0; ADD r0,0x20; JNC 0. Expected: r0=0x10 and C=1, so JNC falls through; ip=3 after 6 cycles post-IDLE.
- Hold mem_ready low 3 cycles on the first fetch. Expected: mem_addr stays 0, no state change, first EXEC on cycle 5.
- IN r1 with io_in=0x5A, then OUT r1. Expected: io_out=0x5A and a single io_out_strobe pulse.
- ADDR_W=4, JMP 15, then fetch at 15 holds ADD. Expected: next mem_addr=0.
- HALT. Expected: halted=1, mem_req=0 indefinitely; n_reset low 1 cycle returns all outputs to reset values.
- STACK_EN, STACK_DEPTH=2: CALL×3. Expected: third CALL sets fault=1 and halted=1 with ip unchanged. RET on an empty stack gives the same result.
